inmultitor_reconstructie: RTL and testbench

//   Sequential shift-and-add multiply-accumulate: computes p = q*b + r over N iterations.
//   It is the inverse of the restoring divider. It rebuilds the dividend from quotient,

---
 rtl/arith_pkg.sv | 14 +
 rtl/inmultitor_reconstructie_sumator.sv | 14 +
 rtl/inmultitor_reconstructie.sv | 92 +++++++++
 tb/tb_inmultitor_reconstructie.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding used by the
// divider and its reconstructing multiplier, plus the iteration counter width.
package arith_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // One extra bit beyond log2(N) so the counter can reach N without wrapping.
  function automatic int CNT_W(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/inmultitor_reconstructie_sumator.sv
// Parameterised unsigned adder used for the accumulate step of the
// shift-and-add multiplier. The result is kept at W bits because the caller
// guarantees that the sum never exceeds the operand width.
module sumator_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/inmultitor_reconstructie.sv
// Sequential shift-and-add multiply-accumulate, p = q*b + r.
// Rebuilds a dividend from the restoring divider's quotient, divisor and
// remainder. Uses the same start/ready handshake as the divider: one
// iteration per clock while busy, and the final iteration writes p directly
// so back-to-back jobs complete every N+1 cycles.
module inmultitor_reconstructie
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   q,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   r,
  output logic [2*N-1:0] p,
  output logic           ready,
  output logic           busy
);

  localparam int CW = CNT_W(N);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   q_reg;
  logic [N-1:0]   b_reg;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] partial;
  logic [2*N-1:0] acc_next;
  logic           q_bit;
  logic           last_iter;
  logic           accept;

  // Multiplier bit for the current iteration, selected with a one-hot mask so
  // the counter's extra headroom bit never produces an out-of-range select.
  assign q_bit = |(q_reg & ({{(N-1){1'b0}}, 1'b1} << cnt));

  // Zero-extended, shifted multiplicand when the current multiplier bit is set.
  assign partial = q_bit ? ({{N{1'b0}}, b_reg} << cnt) : '0;

  assign last_iter = (cnt == CW'(N - 1));
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == CALC);

  sumator_n #(
    .W(2 * N)
  ) u_sumator (
    .a  (acc),
    .b  (partial),
    .sum(acc_next)
  );

  // Control FSM and datapath registers: latch on accept, accumulate in CALC,
  // publish the result and pulse ready on the last iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      q_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      p     <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            state <= DONE;
            p     <= acc_next;
            ready <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state <= CALC;
            q_reg <= q;
            b_reg <= b;
            acc   <= {{N{1'b0}}, r};
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inmultitor_reconstructie.sv
// Self-checking bench for the reconstructing multiplier: directed scenarios,
// randomized jobs against an arithmetic model, and the divider round trip
// (a -> a/b, a%b -> q*b+r) for N=4 and N=6.
module tb_inmultitor_reconstructie;

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start6;
  logic [3:0] q4, b4, r4;
  logic [7:0] p4;
  logic       ready4, busy4;
  logic [5:0] q6, b6, r6;
  logic [11:0] p6;
  logic       ready6, busy6;

  int vectors     = 0;
  int miscompares = 0;

  inmultitor_reconstructie #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .q(q4), .b(b4), .r(r4),
    .p(p4), .ready(ready4), .busy(busy4)
  );

  inmultitor_reconstructie #(.N(6)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .q(q6), .b(b6), .r(r6),
    .p(p6), .ready(ready6), .busy(busy6)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // One N=4 job: start for one cycle, scramble inputs afterwards, then wait
  // (bounded) for ready. lat counts negedges after the accepting edge; -1 on timeout.
  task automatic do_job4(input logic [3:0] qi, bi, ri,
                         output logic [7:0] pres, output int lat, output int busy_cnt);
    bit done = 0;
    @(negedge clk);
    q4 = qi; b4 = bi; r4 = ri; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    q4 = 4'($urandom); b4 = 4'($urandom); r4 = 4'($urandom);
    lat = -1; busy_cnt = 0; pres = 'x;
    for (int k = 0; k < 20 && !done; k++) begin
      if (busy4) busy_cnt++;
      if (ready4) begin
        lat = k; pres = p4; done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Same as do_job4 for the N=6 instance (latency only, no busy count).
  task automatic do_job6(input logic [5:0] qi, bi, ri,
                         output logic [11:0] pres, output int lat);
    bit done = 0;
    @(negedge clk);
    q6 = qi; b6 = bi; r6 = ri; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    q6 = 6'($urandom); b6 = 6'($urandom); r6 = 6'($urandom);
    lat = -1; pres = 'x;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ready6) begin
        lat = k; pres = p6; done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start4 = 0; start6 = 0;
    q4 = 0; b4 = 0; r4 = 0; q6 = 0; b6 = 0; r6 = 0;
    #12;
    vectors++;
    if ({p4, ready4, busy4} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset4: got p=%0d ready=%b busy=%b, required 0 0 0", p4, ready4, busy4);
    end
    vectors++;
    if ({p6, ready6, busy6} !== 14'b0) begin
      miscompares++;
      $display("[TB] FAIL reset6: got p=%0d ready=%b busy=%b, required 0 0 0", p6, ready6, busy6);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] pr; int lat, bc;
    do_job4(4'd3, 4'd5, 4'd2, pr, lat, bc);
    vectors++;
    if (pr !== 8'd17) begin
      miscompares++; $display("[TB] FAIL basic_p: got %0d, required 17", pr);
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++; $display("[TB] FAIL basic_latency: got %0d, required 4", lat);
    end
    vectors++;
    if (bc !== 4) begin
      miscompares++; $display("[TB] FAIL basic_busy_cycles: got %0d, required 4", bc);
    end
    // Result must be held, ready must not re-pulse, while idle.
    repeat (3) @(negedge clk);
    vectors++;
    if ({p4, ready4, busy4} !== {8'd17, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_hold: got p=%0d ready=%b busy=%b, required 17 0 0", p4, ready4, busy4);
    end
  endtask

  task automatic test_corners();
    logic [3:0] tq [3] = '{4'd15, 4'd0, 4'd6};
    logic [3:0] tb [3] = '{4'd15, 4'd9, 4'd0};
    logic [3:0] tr [3] = '{4'd14, 4'd7, 4'd0};
    logic [7:0] pr; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_job4(tq[i], tb[i], tr[i], pr, lat, bc);
      vectors++;
      if (pr !== 8'(tq[i] * tb[i] + tr[i]) || lat !== 4) begin
        miscompares++;
        $display("[TB] FAIL corner_%0d: got p=%0d lat=%0d, required p=%0d lat=4",
                 i, pr, lat, tq[i] * tb[i] + tr[i]);
      end
    end
  endtask

  task automatic test_start_during_calc();
    int pulses = 0; int first = -1; logic [7:0] pr = 'x;
    @(negedge clk);
    q4 = 4'd2; b4 = 4'd7; r4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        q4 = 4'd15; b4 = 4'd15; r4 = 4'd15; start4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      if (ready4) begin
        pulses++;
        if (first < 0) begin first = k; pr = p4; end
      end
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 1 || first !== 4) begin
      miscompares++;
      $display("[TB] FAIL busy_start_ignored: got %0d pulses first at %0d, required 1 at 4", pulses, first);
    end
    vectors++;
    if (pr !== 8'd15) begin
      miscompares++; $display("[TB] FAIL busy_start_p: got %0d, required 15", pr);
    end
  endtask

  task automatic test_back_to_back();
    int t [$]; logic [7:0] v [$];
    @(negedge clk);
    q4 = 4'd4; b4 = 4'd3; r4 = 4'd2; start4 = 1'b1;
    @(negedge clk);
    q4 = 4'd5; b4 = 4'd5; r4 = 4'd0;
    for (int k = 0; k < 15; k++) begin
      if (k == 5) start4 = 1'b0;
      if (ready4) begin t.push_back(k); v.push_back(p4); end
      @(negedge clk);
    end
    vectors++;
    if (t.size() !== 2) begin
      miscompares++; $display("[TB] FAIL b2b_pulse_count: got %0d, required 2", t.size());
    end else begin
      vectors++;
      if (t[1] - t[0] !== 5 || t[0] !== 4) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing: got pulses at %0d,%0d, required 4,9", t[0], t[1]);
      end
      vectors++;
      if (v[0] !== 8'd14 || v[1] !== 8'd25) begin
        miscompares++; $display("[TB] FAIL b2b_p: got %0d,%0d, required 14,25", v[0], v[1]);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [7:0] pr; int lat, bc; int stray = 0;
    @(negedge clk);
    q4 = 4'd9; b4 = 4'd9; r4 = 4'd9; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({p4, ready4, busy4} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_calc: got p=%0d ready=%b busy=%b, required 0 0 0", p4, ready4, busy4);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ready4) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++; $display("[TB] FAIL reset_no_ready: got %0d pulses, required 0", stray);
    end
    do_job4(4'd1, 4'd1, 4'd1, pr, lat, bc);
    vectors++;
    if (pr !== 8'd2 || lat !== 4) begin
      miscompares++; $display("[TB] FAIL after_reset_job: got p=%0d lat=%0d, required 2 4", pr, lat);
    end
  endtask

  task automatic test_random();
    logic [3:0] qi, bi, ri; logic [7:0] pr; int lat, bc; int exp_p;
    for (int i = 0; i < 40; i++) begin
      qi = 4'($urandom); bi = 4'($urandom); ri = 4'($urandom);
      exp_p = int'(qi) * int'(bi) + int'(ri);
      do_job4(qi, bi, ri, pr, lat, bc);
      vectors++;
      if (int'(pr) !== exp_p || lat !== 4 || bc !== 4) begin
        miscompares++;
        $display("[TB] FAIL random_%0d q=%0d b=%0d r=%0d: got p=%0d lat=%0d busy=%0d, required p=%0d lat=4 busy=4",
                 i, qi, bi, ri, pr, lat, bc, exp_p);
      end
    end
  endtask

  task automatic test_divider_loop4();
    logic [7:0] pr; int lat, bc;
    for (int a = 0; a < 16; a++) begin
      for (int d = 1; d < 16; d++) begin
        do_job4(4'(a / d), 4'(d), 4'(a % d), pr, lat, bc);
        vectors++;
        if (int'(pr) !== a) begin
          miscompares++;
          $display("[TB] FAIL divloop4 a=%0d b=%0d: got %0d, required %0d", a, d, pr, a);
        end
      end
    end
  endtask

  task automatic test_divider_loop6();
    logic [11:0] pr; int lat;
    for (int a = 0; a < 64; a++) begin
      for (int d = 1; d < 64; d++) begin
        do_job6(6'(a / d), 6'(d), 6'(a % d), pr, lat);
        vectors++;
        if (int'(pr) !== a || lat !== 6) begin
          miscompares++;
          $display("[TB] FAIL divloop6 a=%0d b=%0d: got p=%0d lat=%0d, required p=%0d lat=6", a, d, pr, lat, a);
        end
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_start_during_calc();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    test_divider_loop4();
    test_divider_loop6();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
